mul_final_adder: RTL and testbench

Pipelined carry-propagate adder that consumes the redundant sum/carry pair produced by the Wallace-tree compressor of the integer multiplier and resolves it into a single binary product word. It sits directly downstream of the 13-input compressor tree, in the `mul_int` datapath. It splits the addition into two registered half-width stages with a valid/ready handshake on both sides, so downstream backpressure stalls the multiplier cleanly.

---
 rtl/mul_int_pkg.sv | 17 +
 rtl/mul_fadd_half.sv | 18 +
 rtl/mul_final_adder.sv | 130 +++++++++++++
 tb/tb_mul_final_adder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mul_int_pkg.sv
// Shared definitions for the integer multiplier datapath: default width,
// low/high split helper and the inter-stage handshake payload.
package mul_int_pkg;

  localparam int unsigned MUL_DATA_WIDTH = 48;

  // Low half of the final adder; the high half takes the remainder.
  function automatic int unsigned lo_width(input int unsigned data_width);
    return data_width / 2;
  endfunction

  typedef struct packed {
    logic                      valid;
    logic [MUL_DATA_WIDTH-1:0] data;
  } mul_hs_t;

endpackage

// File: rtl/mul_fadd_half.sv
// Parameterized-width binary adder with carry-in and carry-out, used for one
// half of the pipelined final adder.
module mul_fadd_half #(
  parameter int unsigned WIDTH = 24
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum_c,
  output logic             carry_c
);

  logic [WIDTH:0] total_c;

  assign total_c          = (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(cin);
  assign {carry_c, sum_c} = total_c;

endmodule

// File: rtl/mul_final_adder.sv
// Two-stage pipelined carry-propagate adder resolving the compressor sum/carry
// pair into the product word. Optional result_zero flag: MUL_FINAL_ADDER_ZERO_FLAG_EN.
module mul_final_adder
  import mul_int_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MUL_DATA_WIDTH,
  parameter int unsigned LO_WIDTH   = lo_width(DATA_WIDTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] sout,
  input  logic [DATA_WIDTH-1:0] cout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result
`ifdef MUL_FINAL_ADDER_ZERO_FLAG_EN
  ,
  output logic                  result_zero
`endif
);

  localparam int unsigned HI_WIDTH = DATA_WIDTH - LO_WIDTH;

  if ((DATA_WIDTH % 2) != 0 || DATA_WIDTH < 4 || LO_WIDTH < 1 || LO_WIDTH >= DATA_WIDTH)
  begin : g_param_check
    $error("mul_final_adder: illegal DATA_WIDTH/LO_WIDTH");
  end

  // Carry vector is weighted one bit up; its MSB falls off the word.
  logic [DATA_WIDTH-1:0] addend_b_c;
  assign addend_b_c = {cout[DATA_WIDTH-2:0], 1'b0};

  logic out_adv_c;
  logic s1_adv_c;
  logic accept_c;

  logic                s1_valid;
  logic [LO_WIDTH-1:0] s1_lo_sum;
  logic                s1_lo_carry;
  logic [HI_WIDTH-1:0] s1_a_hi;
  logic [HI_WIDTH-1:0] s1_b_hi;

  logic [LO_WIDTH-1:0] lo_sum_c;
  logic                lo_carry_c;
  logic [HI_WIDTH-1:0] hi_sum_c;
  logic                hi_carry_c;

  assign out_adv_c = !out_valid || out_ready;
  assign s1_adv_c  = s1_valid && out_adv_c;
  assign in_ready  = !s1_valid || out_adv_c;
  assign accept_c  = in_valid && in_ready;

  mul_fadd_half #(.WIDTH(LO_WIDTH)) u_lo_add (
    .a       (sout[LO_WIDTH-1:0]),
    .b       (addend_b_c[LO_WIDTH-1:0]),
    .cin     (1'b0),
    .sum_c   (lo_sum_c),
    .carry_c (lo_carry_c)
  );

  mul_fadd_half #(.WIDTH(HI_WIDTH)) u_hi_add (
    .a       (s1_a_hi),
    .b       (s1_b_hi),
    .cin     (s1_lo_carry),
    .sum_c   (hi_sum_c),
    .carry_c (hi_carry_c)
  );

  // Final carry-out and the carry vector MSB are dropped by the mod-2^N result.
  logic unused_bits;
  assign unused_bits = &{1'b0, hi_carry_c, cout[DATA_WIDTH-1]};

  // Stage 1: low-half add plus the operands of the high half.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_lo_sum   <= '0;
      s1_lo_carry <= 1'b0;
      s1_a_hi     <= '0;
      s1_b_hi     <= '0;
    end else begin
      if (accept_c) begin
        s1_valid    <= 1'b1;
        s1_lo_sum   <= lo_sum_c;
        s1_lo_carry <= lo_carry_c;
        s1_a_hi     <= sout[DATA_WIDTH-1:LO_WIDTH];
        s1_b_hi     <= addend_b_c[DATA_WIDTH-1:LO_WIDTH];
      end else if (s1_adv_c) begin
        s1_valid    <= 1'b0;
      end
    end
  end

  // Stage 2: output register; holds while the consumer stalls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      if (s1_adv_c) begin
        out_valid <= 1'b1;
        result    <= {hi_sum_c, s1_lo_sum};
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MUL_FINAL_ADDER_ZERO_FLAG_EN
  logic s1_lo_zero;

  // Low-half zero test is done in stage 1 to shorten the stage-2 path.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_lo_zero  <= 1'b0;
      result_zero <= 1'b0;
    end else begin
      if (accept_c) begin
        s1_lo_zero <= (lo_sum_c == '0);
      end
      if (s1_adv_c) begin
        result_zero <= s1_lo_zero && (hi_sum_c == '0);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mul_final_adder.sv
// Directed and random-stream bench for mul_final_adder; zero-flag checks are
// compiled in with MUL_FINAL_ADDER_ZERO_FLAG_EN.
module tb_mul_final_adder;

  localparam int unsigned DW = 48;
  localparam int NUM_RND = 10000;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] sout;
  logic [DW-1:0] cout;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;
`ifdef MUL_FINAL_ADDER_ZERO_FLAG_EN
  logic          result_zero;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  mul_final_adder #(.DATA_WIDTH(DW)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sout      (sout),
    .cout      (cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
`ifdef MUL_FINAL_ADDER_ZERO_FLAG_EN
    ,
    .result_zero (result_zero)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One isolated transaction through an empty pipeline, with latency checks.
  task automatic run_single(input string tag, input logic [DW-1:0] s,
                            input logic [DW-1:0] c, input logic [DW-1:0] exp);
    @(negedge clock);
    sout = s; cout = c; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clock);
    in_valid = 1'b0; sout = '0; cout = '0;
    #1 chk({tag, "_early"}, 64'(out_valid), 64'd0);
    @(negedge clock);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_result"}, 64'(result), 64'(exp));
`ifdef MUL_FINAL_ADDER_ZERO_FLAG_EN
    chk({tag, "_zero"}, 64'(result_zero), 64'(exp == '0));
`endif
    @(negedge clock);
    chk({tag, "_drained"}, 64'(out_valid), 64'd0);
  endtask

  logic [DW-1:0] q[$];
  logic [DW-1:0] rs, rc, e;
  int sent, rcvd, cyc;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sout = '0; cout = '0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;

    run_single("split_carry", 48'h0000_00FF_FFFF, 48'h0000_0000_0001, 48'h0000_0100_0001);
    run_single("wrap_all_ones", 48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001, 48'h0000_0000_0001);
    run_single("wrap_cout_msb", 48'h0000_0000_0005, 48'h8000_0000_0000, 48'h0000_0000_0005);
    run_single("mixed", 48'h1234_5678_9ABC, 48'h0000_1111_0000, 48'h1234_789A_9ABC);
`ifdef MUL_FINAL_ADDER_ZERO_FLAG_EN
    run_single("zero_wrap", 48'h8000_0000_0000, 48'h4000_0000_0000, 48'h0000_0000_0000);
    run_single("nonzero_one", 48'h0000_0000_0001, 48'h0000_0000_0000, 48'h0000_0000_0001);
`endif

    // Backpressure: A=0x12, B=0x24, C=0x36 with the consumer stalled.
    @(negedge clock);
    out_ready = 1'b0; in_valid = 1'b1; sout = 48'h10; cout = 48'h1;
    @(negedge clock);
    sout = 48'h20; cout = 48'h2;
    #1 chk("bp_ready_b", 64'(in_ready), 64'd1);
    @(negedge clock);
    sout = 48'h30; cout = 48'h3;
    #1 chk("bp_ready_c", 64'(in_ready), 64'd0);
    @(negedge clock);
    chk("bp_hold_ready", 64'(in_ready), 64'd0);
    chk("bp_hold_valid", 64'(out_valid), 64'd1);
    chk("bp_hold_a", 64'(result), 64'h12);
    @(negedge clock);
    chk("bp_stable_a", 64'(result), 64'h12);
    out_ready = 1'b1;
    #1 chk("bp_ready_release", 64'(in_ready), 64'd1);
    @(negedge clock);
    in_valid = 1'b0;
    chk("bp_out_b", 64'(result), 64'h24);
    chk("bp_valid_b", 64'(out_valid), 64'd1);
    @(negedge clock);
    chk("bp_out_c", 64'(result), 64'h36);
    chk("bp_valid_c", 64'(out_valid), 64'd1);
    @(negedge clock);
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Reset with both stages full.
    @(negedge clock);
    out_ready = 1'b0; in_valid = 1'b1; sout = 48'h111; cout = 48'h0;
    @(negedge clock);
    sout = 48'h222;
    @(negedge clock);
    in_valid = 1'b0;
    #1 chk("mid_full_ready", 64'(in_ready), 64'd0);
    chk("mid_full_valid", 64'(out_valid), 64'd1);
    #1 reset = 1'b1;
    #1 chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_result", 64'(result), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    @(negedge clock);
    reset = 1'b0;
    run_single("post_reset", 48'h0000_0000_0100, 48'h0000_0000_0080, 48'h0000_0000_0200);

    // Random stream against the arithmetic reference.
    sent = 0; rcvd = 0; cyc = 0;
    while ((sent < NUM_RND || q.size() > 0) && cyc < 60000) begin
      @(negedge clock);
      rs = DW'({$urandom(), $urandom()});
      rc = DW'({$urandom(), $urandom()});
      case ($urandom_range(0, 7))
        0: rs = '1;
        1: rc = '1;
        2: begin rs = '0; rc = '0; end
        default: ;
      endcase
      sout = rs; cout = rc;
      in_valid  = (sent < NUM_RND) && ($urandom_range(0, 3) != 0);
      out_ready = (sent >= NUM_RND) || ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && in_ready) begin
        q.push_back(DW'(65'(rs) + 65'(rc) * 65'd2));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_extra", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("rnd_result", 64'(result), 64'(e));
          rcvd++;
        end
      end
      cyc++;
    end
    in_valid = 1'b0;
    chk("rnd_count", 64'(rcvd), 64'(NUM_RND));
    chk("rnd_leftover", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
